// File: rtl/rega_controle_fsm.sv
// Irrigation controller: synchronizes and debounces the level/soil sensors, then
// runs the fill/water/fault state machine that drives Ve, Vs, ERRO and Estado.

module rega_deb #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC);

    logic          s1_q;
    logic          s2_q;
    logic          cand_q;
    logic          cand_d;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The edge that loads a new candidate already counts as its first match.
    always_comb begin
        cand_d = s2_q;
        if (s2_q != cand_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        filt_d = (cnt_d == CNT_MAX) ? s2_q : filt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cand_q <= 1'b0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;
endmodule

module rega_controle_fsm #(
    parameter int DEB_CYC = 4,
    parameter int T_ENCHE = 1000,
    parameter int T_REGA  = 500
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Nl,
    input  logic       Nm,
    input  logic       Nh,
    input  logic       Us,
    output logic       Ve,
    output logic       Vs,
    output logic       ERRO,
    output logic [1:0] Estado
);
    localparam int T_MAX = (T_ENCHE > T_REGA) ? T_ENCHE : T_REGA;
    localparam int TW    = $clog2(T_MAX) + 1;
    localparam logic [TW-1:0] ENCHE_LIM = TW'(T_ENCHE - 1);
    localparam logic [TW-1:0] REGA_LIM  = TW'(T_REGA - 1);
    localparam logic [TW-1:0] TMR_SAT   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ENCH = 2'b01,
        ST_REGA = 2'b10,
        ST_ERRO = 2'b11
    } state_t;

    logic          nl_f;
    logic          nm_f;
    logic          nh_f;
    logic          us_f;
    logic [2:0]    lvl;
    logic          lvl_ok;
    logic          lvl_empty;
    logic          rega_tout;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic          bloq_q;
    logic          bloq_d;
    logic          ve_q;
    logic          ve_d;
    logic          vs_q;
    logic          vs_d;
    logic          erro_q;
    logic          erro_d;

    function automatic logic level_valid(input logic [2:0] l);
        return (l == 3'b000) || (l == 3'b001) || (l == 3'b011) || (l == 3'b111);
    endfunction

    rega_deb #(.DEB_CYC(DEB_CYC)) u_deb_nl (.clk(Clk), .rst_n(Rst), .din(Nl), .dout(nl_f));
    rega_deb #(.DEB_CYC(DEB_CYC)) u_deb_nm (.clk(Clk), .rst_n(Rst), .din(Nm), .dout(nm_f));
    rega_deb #(.DEB_CYC(DEB_CYC)) u_deb_nh (.clk(Clk), .rst_n(Rst), .din(Nh), .dout(nh_f));
    rega_deb #(.DEB_CYC(DEB_CYC)) u_deb_us (.clk(Clk), .rst_n(Rst), .din(Us), .dout(us_f));

    assign lvl       = {nh_f, nm_f, nl_f};
    assign lvl_ok    = level_valid(lvl);
    assign lvl_empty = (lvl == 3'b000);

    // Branch order inside each state is the conflict-resolution priority.
    always_comb begin
        state_d   = state_q;
        rega_tout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!lvl_ok)                state_d = ST_ERRO;
                else if (lvl_empty)         state_d = ST_ENCH;
                else if (us_f && !bloq_q)   state_d = ST_REGA;
            end
            ST_ENCH: begin
                if (!lvl_ok)                state_d = ST_ERRO;
                else if (nh_f)              state_d = ST_IDLE;
                else if (tmr_q >= ENCHE_LIM) state_d = ST_ERRO;
            end
            ST_REGA: begin
                if (!lvl_ok)                state_d = ST_ERRO;
                else if (lvl_empty)         state_d = ST_ENCH;
                else if (!us_f)             state_d = ST_IDLE;
                else if (tmr_q >= REGA_LIM) begin
                    state_d   = ST_IDLE;
                    rega_tout = 1'b1;
                end
            end
            default: state_d = ST_ERRO;
        endcase

        if (state_d != state_q) begin
            tmr_d = '0;
        end else if ((state_q == ST_ENCH || state_q == ST_REGA) && tmr_q != TMR_SAT) begin
            tmr_d = tmr_q + TW'(1);
        end else begin
            tmr_d = tmr_q;
        end

        // Lockout survives until the soil sensor reads wet again.
        if (!us_f)          bloq_d = 1'b0;
        else if (rega_tout) bloq_d = 1'b1;
        else                bloq_d = bloq_q;

        ve_d   = (state_d == ST_ENCH);
        vs_d   = (state_d == ST_REGA);
        erro_d = (state_d == ST_ERRO);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            bloq_q  <= 1'b0;
            ve_q    <= 1'b0;
            vs_q    <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bloq_q  <= bloq_d;
            ve_q    <= ve_d;
            vs_q    <= vs_d;
            erro_q  <= erro_d;
        end
    end

    assign Ve     = ve_q;
    assign Vs     = vs_q;
    assign ERRO   = erro_q;
    assign Estado = state_q;
endmodule

// File: tb/tb_rega_controle_fsm.sv
// Directed bench for rega_controle_fsm: expectations queued with their due cycle and
// compared at the falling edge of that cycle; async-reset behaviour checked directly.

module tb_rega_controle_fsm;
    localparam int DEB = 4;
    localparam int TE  = 20;
    localparam int TR  = 10;
    localparam int LAT = DEB + 3;

    // {Ve, Vs, ERRO, Estado}
    localparam logic [4:0] S_IDLE = 5'b000_00;
    localparam logic [4:0] S_ENCH = 5'b100_01;
    localparam logic [4:0] S_REGA = 5'b010_10;
    localparam logic [4:0] S_ERRO = 5'b001_11;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Nl = 1'b0, Nm = 1'b0, Nh = 1'b0, Us = 1'b0;
    logic       Ve, Vs, ERRO;
    logic [1:0] Estado;
    logic [4:0] cur;

    rega_controle_fsm #(.DEB_CYC(DEB), .T_ENCHE(TE), .T_REGA(TR)) dut (
        .Clk(Clk), .Rst(Rst), .Nl(Nl), .Nm(Nm), .Nh(Nh), .Us(Us),
        .Ve(Ve), .Vs(Vs), .ERRO(ERRO), .Estado(Estado)
    );

    assign cur = {Ve, Vs, ERRO, Estado};

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        string      tag;
        logic [4:0] exp;
    } item_t;

    item_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed {Ve,Vs,ERRO,Estado}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_in(input int n, input string tag, input logic [4:0] e);
        item_t it;
        it.t   = cyc + n;
        it.tag = tag;
        it.exp = e;
        sb.push_back(it);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_lvl(input logic [2:0] v);
        {Nh, Nm, Nl} = v;
    endtask

    always @(negedge Clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].t == cyc) begin
                chk(sb[i].tag, cur, sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        // Reset held with empty tank
        tick(3);
        chk("reset_state", cur, S_IDLE);
        Rst = 1'b1;
        expect_in(LAT, "release_fill", S_ENCH);

        // Fill sequence, 5 cycles per step
        tick(1);
        set_lvl(3'b001);
        expect_in(5, "fill_001", S_ENCH);
        tick(5);
        set_lvl(3'b011);
        expect_in(3, "fill_011", S_ENCH);
        tick(5);
        set_lvl(3'b111);
        expect_in(LAT - 1, "full_minus1", S_ENCH);
        expect_in(LAT, "full_idle", S_IDLE);

        // Watering on/off and a short glitch
        tick(12);
        set_lvl(3'b011);
        tick(10);
        Us = 1'b1;
        expect_in(LAT - 1, "us_on_minus1", S_IDLE);
        expect_in(LAT, "us_on", S_REGA);
        tick(LAT + 1);
        Us = 1'b0;
        expect_in(LAT - 1, "us_off_minus1", S_REGA);
        expect_in(LAT, "us_off", S_IDLE);
        tick(LAT + 2);
        Us = 1'b1;
        tick(3);
        Us = 1'b0;
        expect_in(LAT, "glitch_a", S_IDLE);
        expect_in(LAT + 4, "glitch_b", S_IDLE);

        // Watering timeout and lockout
        tick(12);
        Us = 1'b1;
        expect_in(LAT + TR - 1, "rega_last", S_REGA);
        expect_in(LAT + TR, "rega_tout", S_IDLE);
        expect_in(LAT + TR + 8, "bloq_hold", S_IDLE);
        tick(25);
        Us = 1'b0;
        tick(6);
        Us = 1'b1;
        expect_in(LAT - 1, "rewater_minus1", S_IDLE);
        expect_in(LAT, "rewater", S_REGA);
        tick(LAT + 1);
        Us = 1'b0;
        expect_in(LAT, "rewater_off", S_IDLE);

        // Invalid level fault, sticky until reset
        tick(LAT + 3);
        set_lvl(3'b101);
        expect_in(LAT - 1, "bad_lvl_minus1", S_IDLE);
        expect_in(LAT, "bad_lvl", S_ERRO);
        tick(LAT + 2);
        set_lvl(3'b111);
        expect_in(15, "erro_sticky", S_ERRO);
        tick(16);
        Rst = 1'b0;
        #1;
        chk("rst_clears_erro", cur, S_IDLE);
        tick(2);
        Rst = 1'b1;
        expect_in(2, "post_rst_fill", S_ENCH);
        expect_in(LAT, "post_rst_idle", S_IDLE);

        // Fill timeout
        tick(LAT + 2);
        set_lvl(3'b000);
        expect_in(LAT, "fill_start", S_ENCH);
        expect_in(LAT + TE - 1, "fill_last", S_ENCH);
        expect_in(LAT + TE, "fill_tout", S_ERRO);
        tick(LAT + TE + 2);

        // Async reset in the middle of a fill
        Rst = 1'b0;
        tick(2);
        Rst = 1'b1;
        expect_in(LAT, "refill", S_ENCH);
        tick(LAT + 3);
        #3;
        Rst = 1'b0;
        #1;
        chk("rst_mid_fill", cur, S_IDLE);
        tick(2);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drained: pending=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
